// File: rtl/fsm_table_seq.sv
`default_nettype none
// ============================================================================
// Module   : fsm_table_seq
// Purpose  : Table-driven Mealy automaton with a writable transition/output
//            table, run/hold control and an illegal-state trap. Each table
//            entry at {state, x} holds {next_state, t}.
// Options  : FSM_TABLE_SEQ_OUT_REG_EN - when defined, t is registered and
//            aligned with the new state; otherwise t is combinational.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_table_seq #(
  parameter int NS = 9,   // number of legal states, 2..2^SW
  parameter int SW = 4,   // state register width
  parameter int XW = 2,   // condition input width
  parameter int TW = 5    // action output width
) (
  input  logic             clk,
  input  logic             res,       // asynchronous, active-low
  input  logic             run,
  input  logic [XW-1:0]    x,
  output logic [TW-1:0]    t,
  output logic [SW-1:0]    st,
  input  logic             cfg_we,
  input  logic [SW+XW-1:0] cfg_addr,
  input  logic [SW+TW-1:0] cfg_data,
  output logic             cfg_err,
  output logic             bad
);

  localparam int AW    = SW + XW;
  localparam int EW    = SW + TW;
  localparam int DEPTH = NS * (2 ** XW);

  // One extra bit so that NS == 2^SW and DEPTH == 2^AW remain representable.
  localparam logic [SW:0] NS_W    = (SW + 1)'(NS);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  // Transition/output table, one register per {state, x} pair.
  logic [EW-1:0] tbl [DEPTH];

  logic [AW-1:0] rd_idx;
  logic [EW-1:0] entry;
  logic [SW-1:0] e_next;
  logic [TW-1:0] e_t;
  logic [SW-1:0] cfg_state;
  logic          trap;
  logic          wr_ok;

  assign rd_idx    = {st, x};
  assign e_next    = entry[EW-1:TW];
  assign e_t       = entry[TW-1:0];
  assign cfg_state = cfg_addr[AW-1:XW];

  // A step whose target lies outside the legal state range is trapped.
  assign trap  = run && ({1'b0, e_next} >= NS_W);

  // Writes are only taken while holding and only into legal-state rows.
  assign wr_ok = cfg_we && !run && ({1'b0, cfg_state} < NS_W);

  // Combinational lookup of the entry for the current state and inputs.
  always_comb begin
    entry = '0;
    if ({1'b0, rd_idx} < DEPTH_W) begin
      entry = tbl[rd_idx];
    end
  end

  // Table storage: cleared by reset, updated by accepted configuration writes.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else if (wr_ok) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // State register plus the one-cycle trap and write-reject pulses.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      st      <= '0;
      bad     <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      bad     <= trap;
      cfg_err <= cfg_we && !wr_ok;
      if (run) begin
        st <= trap ? '0 : e_next;
      end
    end
  end

`ifdef FSM_TABLE_SEQ_OUT_REG_EN
  // Registered action output, aligned with the state it leads into.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      t <= '0;
    end else begin
      t <= run ? e_t : '0;
    end
  end
`else
  // Mealy action output straight from the lookup; forced to zero on hold.
  always_comb begin
    t = run ? e_t : '0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm_table_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_table_seq
// Purpose  : Directed self-checking bench for fsm_table_seq (default params).
//            Inputs change just after the falling edge; registered outputs
//            are sampled at the falling edge, combinational ones 1 unit later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_table_seq;

  localparam int NS = 9;
  localparam int SW = 4;
  localparam int XW = 2;
  localparam int TW = 5;

  logic             clk = 1'b0;
  logic             res;
  logic             run;
  logic [XW-1:0]    x;
  logic [TW-1:0]    t;
  logic [SW-1:0]    st;
  logic             cfg_we;
  logic [SW+XW-1:0] cfg_addr;
  logic [SW+TW-1:0] cfg_data;
  logic             cfg_err;
  logic             bad;

  int checks = 0;
  int errors = 0;

  logic [XW-1:0] xs  [3];
  logic [TW-1:0] ts  [3];
  logic [SW-1:0] sts [3];

  fsm_table_seq #(.NS(NS), .SW(SW), .XW(XW), .TW(TW)) dut (
    .clk      (clk),
    .res      (res),
    .run      (run),
    .x        (x),
    .t        (t),
    .st       (st),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err),
    .bad      (bad)
  );

  always #5 clk = ~clk;

  // Holds the machine and issues one write strobe; returns on the next falling
  // edge, where cfg_err for that write is visible.
  task automatic write_entry(input logic [SW+XW-1:0] addr, input logic [SW+TW-1:0] data);
    run      = 1'b0;
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // One step from the current state with the given x, then hold again.
  task automatic plain_step(input logic [XW-1:0] xv);
    run = 1'b1;
    x   = xv;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic test_reset;
    res = 1'b0; run = 1'b0; x = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (st !== 4'd0)  begin errors++; $display("FAIL reset_st: got %0h expected 0", st); end
    checks++; if (t !== 5'd0)   begin errors++; $display("FAIL reset_t: got %0h expected 0", t); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL reset_bad: got %b expected 0", bad); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
    res = 1'b1; run = 1'b1; x = 2'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (st !== 4'd0)  begin errors++; $display("FAIL default_st[%0d]: got %0h expected 0", i, st); end
      checks++; if (t !== 5'd0)   begin errors++; $display("FAIL default_t[%0d]: got %0h expected 0", i, t); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL default_bad[%0d]: got %b expected 0", i, bad); end
    end
    @(negedge clk);
    run = 1'b0; x = '0;
  endtask

  task automatic test_load_step;
    write_entry(6'd0, {4'd1, 5'h04});
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL load_err0: got %b expected 0", cfg_err); end
    write_entry(6'd5, {4'd2, 5'h10});
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL load_err5: got %b expected 0", cfg_err); end
    write_entry(6'd9, {4'd8, 5'h01});
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL load_err9: got %b expected 0", cfg_err); end
    xs  = '{2'd0, 2'd1, 2'd1};
    ts  = '{5'h04, 5'h10, 5'h01};
    sts = '{4'd1, 4'd2, 4'd8};
    for (int i = 0; i < 3; i++) begin
      run = 1'b1; x = xs[i]; #1;
`ifndef FSM_TABLE_SEQ_OUT_REG_EN
      checks++; if (t !== ts[i]) begin errors++; $display("FAIL step_t[%0d]: got %0h expected %0h", i, t, ts[i]); end
`endif
      @(negedge clk);
      checks++; if (st !== sts[i]) begin errors++; $display("FAIL step_st[%0d]: got %0h expected %0h", i, st, sts[i]); end
`ifdef FSM_TABLE_SEQ_OUT_REG_EN
      checks++; if (t !== ts[i]) begin errors++; $display("FAIL step_t_reg[%0d]: got %0h expected %0h", i, t, ts[i]); end
`endif
    end
    run = 1'b0;
    @(negedge clk); #1;
    checks++; if (st !== 4'd8) begin errors++; $display("FAIL hold_st: got %0h expected 8", st); end
    checks++; if (t !== 5'd0)  begin errors++; $display("FAIL hold_t: got %0h expected 0", t); end
    @(negedge clk);
    plain_step(2'd0);
    checks++; if (st !== 4'd0) begin errors++; $display("FAIL back_to_0: got %0h expected 0", st); end
  endtask

  task automatic test_reject_run;
    run = 1'b1; x = 2'd0; cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = {4'd3, 5'h1F};
    #1;
`ifndef FSM_TABLE_SEQ_OUT_REG_EN
    checks++; if (t !== 5'h04) begin errors++; $display("FAIL rej_run_t: got %0h expected 04", t); end
`endif
    @(negedge clk);
    cfg_we = 1'b0; run = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rej_run_err: got %b expected 1", cfg_err); end
    checks++; if (st !== 4'd1) begin errors++; $display("FAIL rej_run_st: got %0h expected 1", st); end
`ifdef FSM_TABLE_SEQ_OUT_REG_EN
    checks++; if (t !== 5'h04) begin errors++; $display("FAIL rej_run_t_reg: got %0h expected 04", t); end
`endif
    @(negedge clk);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rej_run_err_clear: got %b expected 0", cfg_err); end
    plain_step(2'd0);
    plain_step(2'd0);
    checks++; if (st !== 4'd1) begin errors++; $display("FAIL rej_run_old_entry: got %0h expected 1", st); end
    plain_step(2'd0);
  endtask

  task automatic test_reject_addr;
    write_entry({4'd9, 2'd0}, {4'd3, 5'h1F});
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rej_addr9_err: got %b expected 1", cfg_err); end
    @(negedge clk);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rej_addr_clear: got %b expected 0", cfg_err); end
    write_entry({4'd15, 2'd3}, {4'd3, 5'h1F});
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rej_addr15_err: got %b expected 1", cfg_err); end
    write_entry({4'd8, 2'd3}, {4'd0, 5'h15});
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL acc_addr8_err: got %b expected 0", cfg_err); end
    run = 1'b1; x = 2'd0; #1;
`ifndef FSM_TABLE_SEQ_OUT_REG_EN
    checks++; if (t !== 5'h04) begin errors++; $display("FAIL rej_addr_t: got %0h expected 04", t); end
`endif
    @(negedge clk);
    run = 1'b0;
    checks++; if (st !== 4'd1) begin errors++; $display("FAIL rej_addr_st: got %0h expected 1", st); end
    plain_step(2'd0);
  endtask

  task automatic test_trap;
    write_entry(6'd0, {4'd12, 5'h1F});
    write_entry(6'd1, {4'd9, 5'h0A});
    xs = '{2'd0, 2'd1, 2'd0};
    ts = '{5'h1F, 5'h0A, 5'h00};
    for (int i = 0; i < 2; i++) begin
      run = 1'b1; x = xs[i]; #1;
`ifndef FSM_TABLE_SEQ_OUT_REG_EN
      checks++; if (t !== ts[i]) begin errors++; $display("FAIL trap_t[%0d]: got %0h expected %0h", i, t, ts[i]); end
`endif
      @(negedge clk);
      run = 1'b0;
      checks++; if (st !== 4'd0)  begin errors++; $display("FAIL trap_st[%0d]: got %0h expected 0", i, st); end
      checks++; if (bad !== 1'b1) begin errors++; $display("FAIL trap_bad[%0d]: got %b expected 1", i, bad); end
`ifdef FSM_TABLE_SEQ_OUT_REG_EN
      checks++; if (t !== ts[i]) begin errors++; $display("FAIL trap_t_reg[%0d]: got %0h expected %0h", i, t, ts[i]); end
`endif
      @(negedge clk);
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL trap_bad_clear[%0d]: got %b expected 0", i, bad); end
    end
  endtask

  task automatic test_back_to_back;
    write_entry(6'd0, {4'd2, 5'h03});
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b expected 0", cfg_err); end
    run = 1'b1; x = 2'd0; #1;
`ifndef FSM_TABLE_SEQ_OUT_REG_EN
    checks++; if (t !== 5'h03) begin errors++; $display("FAIL b2b_t: got %0h expected 03", t); end
`endif
    @(negedge clk);
    checks++; if (st !== 4'd2)  begin errors++; $display("FAIL b2b_st: got %0h expected 2", st); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL b2b_bad: got %b expected 0", bad); end
`ifdef FSM_TABLE_SEQ_OUT_REG_EN
    checks++; if (t !== 5'h03) begin errors++; $display("FAIL b2b_t_reg: got %0h expected 03", t); end
`endif
  endtask

  task automatic test_mid_reset;
    run = 1'b1; x = 2'd1; cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = '0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    checks++; if (st !== 4'd8)      begin errors++; $display("FAIL pre_rst_st: got %0h expected 8", st); end
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL pre_rst_err: got %b expected 1", cfg_err); end
`ifdef FSM_TABLE_SEQ_OUT_REG_EN
    checks++; if (t !== 5'h01) begin errors++; $display("FAIL pre_rst_t_reg: got %0h expected 01", t); end
`endif
    #1; res = 1'b0; #1;
    checks++; if (st !== 4'd0)      begin errors++; $display("FAIL rst_st: got %0h expected 0", st); end
    checks++; if (t !== 5'd0)       begin errors++; $display("FAIL rst_t: got %0h expected 0", t); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", cfg_err); end
    checks++; if (bad !== 1'b0)     begin errors++; $display("FAIL rst_bad: got %b expected 0", bad); end
    @(negedge clk);
    res = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = 2'(i); #1;
      checks++; if (t !== 5'd0) begin errors++; $display("FAIL cleared_t[%0d]: got %0h expected 0", i, t); end
      @(negedge clk);
      checks++; if (st !== 4'd0)  begin errors++; $display("FAIL cleared_st[%0d]: got %0h expected 0", i, st); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL cleared_bad[%0d]: got %b expected 0", i, bad); end
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_step();
    test_reject_run();
    test_reject_addr();
    test_trap();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
